// File: rtl/approx_mult_pkg.sv
// rtl/approx_mult_pkg.sv - shared constants, state type and keep clamp for the approximate multiplier
package approx_mult_pkg;

  localparam int WIDTH        = 8;
  localparam int KEEP_W       = 4;
  localparam int KEEP_DEFAULT = 5;
  localparam int IDX_W        = $clog2(WIDTH);
  localparam int PROD_W       = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Any requested depth beyond the operand width keeps every partial product.
  function automatic logic [KEEP_W-1:0] clamp_keep(input logic [KEEP_W-1:0] k);
    if (k > KEEP_W'(WIDTH)) begin
      return KEEP_W'(WIDTH);
    end
    return k;
  endfunction

endpackage

// File: rtl/approx_pp_step.sv
// rtl/approx_pp_step.sv - one shift-add slice of the partial-product accumulator
module approx_pp_step
  import approx_mult_pkg::*;
(
  input  logic [PROD_W-1:0] i_acc,
  input  logic [WIDTH-1:0]  i_a,
  input  logic              i_b_bit,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [PROD_W-1:0] o_acc_next
);

  logic [PROD_W-1:0] w_pp;

  // Partial product for multiplier bit idx, added only when that bit is set.
  assign w_pp       = {{(PROD_W-WIDTH){1'b0}}, i_a} << i_idx;
  assign o_acc_next = i_b_bit ? (i_acc + w_pp) : i_acc;

endmodule

// File: rtl/approx_mult_seq_ctrl.sv
// rtl/approx_mult_seq_ctrl.sv - sequential truncated-partial-product 8x8 multiplier with valid/ready handshake
module approx_mult_seq_ctrl
  import approx_mult_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  logic              i_keep_sel,
  input  logic [KEEP_W-1:0] i_keep,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [PROD_W-1:0] o_c,
  output logic              o_busy
);

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [PROD_W-1:0] r_acc;
  logic [IDX_W-1:0]  r_idx;
  logic [KEEP_W-1:0] r_cnt;
  logic              r_out_valid;
  logic              r_busy;

  logic [KEEP_W-1:0] w_keep_eff;
  logic [PROD_W-1:0] w_acc_next;
  logic              w_accept;

  // Depth chosen per operation, clamped so the counter never outruns the operand bits.
  assign w_keep_eff  = clamp_keep(i_keep_sel ? i_keep : KEEP_W'(KEEP_DEFAULT));
  assign o_in_ready  = (r_state == IDLE) && i_rst_n;
  assign w_accept    = i_in_valid && o_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_c         = r_acc;

  approx_pp_step u_step (
    .i_acc      (r_acc),
    .i_a        (r_a),
    .i_b_bit    (r_b[r_idx]),
    .i_idx      (r_idx),
    .o_acc_next (w_acc_next)
  );

  // Control FSM: accept operands, walk the kept partial products MSB-first, hold the result until taken.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a    <= i_a;
            r_b    <= i_b;
            r_acc  <= '0;
            r_idx  <= IDX_W'(WIDTH - 1);
            r_cnt  <= w_keep_eff;
            r_busy <= 1'b1;
            if (w_keep_eff == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx - IDX_W'(1);
          r_cnt <= r_cnt - KEEP_W'(1);
          if (r_cnt == KEEP_W'(1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
